// File: rtl/k005297_sumgen_if.sv
// Signal bundle between the K005297 write sequencer (master) and the page
// checksum generator (slave).
interface k005297_sumgen_if;
  // Strobe semantics: i_BDO_STB and o_SUM_STB qualify their bit only on a tick
  // (i_MCLK rise with i_CLK2M_PCEN_n low); there is no back-pressure.
  logic       i_CLK2M_PCEN_n;
  logic       i_UMODE_n;
  logic       i_PAGE_START;
  logic       i_BDO_BIT;
  logic       i_BDO_STB;
  logic       i_SUM_REQ;
  logic       o_SUM_BIT;
  logic       o_SUM_STB;
  logic       o_SUM_DONE;
  logic       o_BUSY;
  logic       o_WORD_ERR;
  logic [1:0] o_DBG_STATE;

  modport master (
    output i_CLK2M_PCEN_n, i_UMODE_n, i_PAGE_START, i_BDO_BIT, i_BDO_STB, i_SUM_REQ,
    input  o_SUM_BIT, o_SUM_STB, o_SUM_DONE, o_BUSY, o_WORD_ERR, o_DBG_STATE
  );

  modport slave (
    input  i_CLK2M_PCEN_n, i_UMODE_n, i_PAGE_START, i_BDO_BIT, i_BDO_STB, i_SUM_REQ,
    output o_SUM_BIT, o_SUM_STB, o_SUM_DONE, o_BUSY, o_WORD_ERR, o_DBG_STATE
  );
endinterface

// File: rtl/k005297_sumgen.sv
// Write-path page checksum: modular word sum over the outgoing bubble stream,
// emitted LSB-first on request. Width is 12 (bootloader) or 8 (user) bits.
module k005297_sumgen #(
  parameter int BOOT_W = 12,
  parameter int USER_W = 8
) (
  input logic              i_MCLK,
  input logic              i_RST,
  k005297_sumgen_if.slave  bus
);
  localparam int MAX_W = BOOT_W;
  localparam int CW    = $clog2(MAX_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2
  } state_t;

  state_t           state_q;
  logic             user_q;
  logic [MAX_W-1:0] sum_q, word_q;
  logic [CW-1:0]    bit_cnt_q, emit_cnt_q;
  logic             sum_bit_q, sum_stb_q, sum_done_q, busy_q, word_err_q;

  logic             tick;
  logic [CW-1:0]    w_cnt, w_last;
  logic [MAX_W-1:0] mask;
  logic [MAX_W-1:0] word_d, sum_d;
  logic [CW-1:0]    bit_cnt_d;

  assign tick = ~bus.i_CLK2M_PCEN_n;

  // Bit acceptance and word completion, so a same-tick request sees the final add.
  always_comb begin
    w_cnt     = user_q ? CW'(USER_W) : CW'(BOOT_W);
    w_last    = w_cnt - CW'(1);
    mask      = user_q ? MAX_W'({USER_W{1'b1}}) : {MAX_W{1'b1}};
    word_d    = word_q;
    sum_d     = sum_q;
    bit_cnt_d = bit_cnt_q;
    if (bus.i_BDO_STB) begin
      word_d = word_q | (MAX_W'(bus.i_BDO_BIT) << bit_cnt_q);
      if (bit_cnt_q == w_last) begin
        sum_d     = (sum_q + word_d) & mask;
        word_d    = '0;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q    <= S_IDLE;
      user_q     <= 1'b0;
      sum_q      <= '0;
      word_q     <= '0;
      bit_cnt_q  <= '0;
      emit_cnt_q <= '0;
      sum_bit_q  <= 1'b0;
      sum_stb_q  <= 1'b0;
      sum_done_q <= 1'b0;
      busy_q     <= 1'b0;
      word_err_q <= 1'b0;
    end else if (tick) begin
      sum_done_q <= 1'b0;
      if (bus.i_PAGE_START) begin
        user_q     <= ~bus.i_UMODE_n;
        sum_q      <= '0;
        word_q     <= '0;
        bit_cnt_q  <= '0;
        emit_cnt_q <= '0;
        sum_bit_q  <= 1'b0;
        sum_stb_q  <= 1'b0;
        busy_q     <= 1'b1;
        word_err_q <= 1'b0;
        state_q    <= S_ACCUM;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_ACCUM: begin
            word_q    <= word_d;
            sum_q     <= sum_d;
            bit_cnt_q <= bit_cnt_d;
            if (bus.i_SUM_REQ) begin
              // A partial word is dropped and flagged; the sum is emitted as-is.
              if (bit_cnt_d != '0) word_err_q <= 1'b1;
              word_q     <= '0;
              bit_cnt_q  <= '0;
              sum_bit_q  <= sum_d[0];
              sum_stb_q  <= 1'b1;
              emit_cnt_q <= CW'(1);
              state_q    <= S_EMIT;
            end
          end
          S_EMIT: begin
            if (emit_cnt_q == w_cnt) begin
              sum_bit_q  <= 1'b0;
              sum_stb_q  <= 1'b0;
              sum_done_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= S_IDLE;
            end else begin
              sum_bit_q  <= sum_q[emit_cnt_q];
              emit_cnt_q <= emit_cnt_q + CW'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.o_SUM_BIT   = sum_bit_q;
  assign bus.o_SUM_STB   = sum_stb_q;
  assign bus.o_SUM_DONE  = sum_done_q;
  assign bus.o_BUSY      = busy_q;
  assign bus.o_WORD_ERR  = word_err_q;
  assign bus.o_DBG_STATE = state_q;
endmodule
